apb_slave_regfile: RTL and testbench

APB3 completer (responder) that answers transfers driven by the APB initiator onto the shared APB signal bundle. It is selected by one psel bit and holds NUM_REGS 32-bit registers at BASE_ADDR. It inserts a fixed number of wait states and flags errors via pslverr. It is used as the target DUT/peripheral model for APB interface UVC examples.

---
 rtl/apb_slave_pkg.sv | 37 +++
 rtl/apb_slave_regs.sv | 35 +++
 rtl/apb_slave_regfile.sv | 179 +++++++++++++++++
 tb/tb_apb_slave_regfile.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// Shared types and response helper for the APB3 register-file completer.
package apb_slave_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] prdata;
        logic                  pslverr;
    } resp_t;

    // Writes never return data; misses and read-only targets raise pslverr.
    function automatic resp_t calc_resp(
        input logic                  is_write,
        input logic                  is_hit,
        input logic                  is_ro,
        input logic [APB_DATA_W-1:0] rdata
    );
        resp_t r;
        r.prdata  = '0;
        r.pslverr = 1'b0;
        if (is_write) begin
            r.pslverr = !is_hit || is_ro;
        end else if (is_hit) begin
            r.prdata = rdata;
        end else begin
            r.pslverr = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_slave_regs.sv
// Register array with read-only gating; read-only entries keep RESET_VAL forever.
module apb_slave_regs
    import apb_slave_pkg::*;
#(
    parameter int unsigned           NUM_REGS  = 16,
    parameter int unsigned           IDX_W     = 4,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = '0,
    parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [APB_DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_ridx,
    output logic [APB_DATA_W-1:0] o_rdata,
    output logic                  o_ro
);

    logic [APB_DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= RESET_VAL;
            end
        end else if (i_we && !RO_MASK[i_widx]) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];
    assign o_ro    = RO_MASK[i_ridx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer: address decode, wait-state counter and transfer FSM over apb_slave_regs.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int unsigned           NUM_REGS    = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [APB_DATA_W-1:0] pwdata,
    output logic [APB_DATA_W-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            err_count
);

    localparam int unsigned           IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [APB_ADDR_W-1:0] SPAN      = APB_ADDR_W'(NUM_REGS * 4);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic                  r_hit;
    logic [IDX_W-1:0]      r_idx;
    logic [APB_DATA_W-1:0] r_wdata;
    logic [APB_DATA_W-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;
    logic [7:0]            r_err_cnt;

    logic [APB_ADDR_W-1:0] w_off;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_rd_write;
    logic                  w_rd_hit;
    logic [IDX_W-1:0]      w_rd_idx;
    logic [APB_DATA_W-1:0] w_rd_data;
    logic                  w_rd_ro;
    resp_t                 w_resp;

    state_t                w_state_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_capture;
    logic                  w_we;
    logic                  w_pready_nxt;
    logic [APB_DATA_W-1:0] w_prdata_nxt;
    logic                  w_pslverr_nxt;
    logic [7:0]            w_err_nxt;

    assign w_off = paddr - BASE_ADDR;
    assign w_hit = (w_off < SPAN) && (paddr[1:0] == 2'b00);
    assign w_idx = w_off[IDX_W+1:2];

    // Zero-wait responses come from the live bus at setup; otherwise from the captured request.
    always_comb begin
        w_rd_write = r_write;
        w_rd_hit   = r_hit;
        w_rd_idx   = r_idx;
        if (r_state == IDLE) begin
            w_rd_write = pwrite;
            w_rd_hit   = w_hit;
            w_rd_idx   = w_idx;
        end
    end

    apb_slave_regs #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RO_MASK   (RO_MASK),
        .RESET_VAL (RESET_VAL)
    ) u_regs (
        .pclk    (pclk),
        .preset  (preset),
        .i_we    (w_we),
        .i_widx  (r_idx),
        .i_wdata (r_wdata),
        .i_ridx  (w_rd_idx),
        .o_rdata (w_rd_data),
        .o_ro    (w_rd_ro)
    );

    assign w_resp = calc_resp(w_rd_write, w_rd_hit, w_rd_ro, w_rd_data);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_capture     = 1'b0;
        w_we          = 1'b0;
        w_pready_nxt  = r_pready;
        w_prdata_nxt  = r_prdata;
        w_pslverr_nxt = r_pslverr;
        w_err_nxt     = r_err_cnt;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = ACCESS;
                    w_capture   = 1'b1;
                    w_cnt_nxt   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        w_pready_nxt  = 1'b1;
                        w_prdata_nxt  = w_resp.prdata;
                        w_pslverr_nxt = w_resp.pslverr;
                    end
                end
            end
            ACCESS: begin
                if (!psel) begin
                    w_state_nxt   = IDLE;
                    w_pready_nxt  = 1'b0;
                    w_prdata_nxt  = '0;
                    w_pslverr_nxt = 1'b0;
                end else if (r_pready) begin
                    if (penable) begin
                        w_we          = r_write && r_hit;
                        w_state_nxt   = IDLE;
                        w_pready_nxt  = 1'b0;
                        w_prdata_nxt  = '0;
                        w_pslverr_nxt = 1'b0;
                        if (r_pslverr && (r_err_cnt != 8'hFF)) begin
                            w_err_nxt = r_err_cnt + 8'd1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_pready_nxt  = 1'b1;
                        w_prdata_nxt  = w_resp.prdata;
                        w_pslverr_nxt = w_resp.pslverr;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_hit     <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            if (w_capture) begin
                r_write <= pwrite;
                r_hit   <= w_hit;
                r_idx   <= w_idx;
                r_wdata <= pwdata;
            end
            r_prdata  <= w_prdata_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_err_cnt <= w_err_nxt;
        end
    end

    assign prdata    = r_prdata;
    assign pready    = r_pready;
    assign pslverr   = r_pslverr;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed + random bench for apb_slave_regfile: two instances (zero-wait and three-wait) against a register-map model.
module tb_apb_slave_regfile;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_B = 32'hA5A5_0000;
    localparam logic [15:0] RO_A = 16'h0001;
    localparam logic [15:0] RO_B = 16'h8002;
    localparam int          W_A  = 0;
    localparam int          W_B  = 3;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel_a, psel_b, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic [7:0]  err_count_a, err_count_b;

    int          cur;
    logic [31:0] o_prdata;
    logic        o_pready, o_pslverr;
    logic [7:0]  o_err_count;

    assign o_prdata    = (cur == 1) ? prdata_b    : prdata_a;
    assign o_pready    = (cur == 1) ? pready_b    : pready_a;
    assign o_pslverr   = (cur == 1) ? pslverr_b   : pslverr_a;
    assign o_err_count = (cur == 1) ? err_count_b : err_count_a;

    always #5 pclk = ~pclk;

    apb_slave_regfile #(
        .NUM_REGS(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(W_A),
        .RO_MASK(RO_A), .RESET_VAL(RV_A)
    ) dut_a (
        .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a),
        .pready(pready_a), .pslverr(pslverr_a), .err_count(err_count_a)
    );

    apb_slave_regfile #(
        .NUM_REGS(16), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(W_B),
        .RO_MASK(RO_B), .RESET_VAL(RV_B)
    ) dut_b (
        .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b),
        .pready(pready_b), .pslverr(pslverr_b), .err_count(err_count_b)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_regs [2][16];
    int          m_err  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m_regs[d][i] = (d == 1) ? RV_B : RV_A;
            m_err[d] = 0;
        end
    endtask

    function automatic bit is_ro(input int d, input int idx);
        logic [15:0] m;
        m = (d == 1) ? RO_B : RO_A;
        return m[idx];
    endfunction

    // One complete transfer starting at edge+1; returns at edge+1 after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off, exp_rd;
        bit          hit, exp_err;
        int          idx, n;
        cur     = d;
        psel_a  = (d == 0);
        psel_b  = (d == 1);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        pwrite  = ~wr;
        n = 1;
        while (o_pready !== 1'b1 && n <= 40) begin
            @(posedge pclk); #1;
            n++;
        end
        off = addr;
        hit = (off < 32'd64) && (addr[1:0] == 2'b00);
        idx = int'(off[5:2]);
        if (wr) begin
            exp_rd  = '0;
            exp_err = !hit || is_ro(d, idx);
        end else begin
            exp_rd  = hit ? m_regs[d][idx] : 32'h0;
            exp_err = !hit;
        end
        check("latency", 32'(n), 32'((d == 1) ? W_B + 1 : W_A + 1));
        check("prdata", o_prdata, exp_rd);
        check("pslverr", {31'b0, o_pslverr}, {31'b0, exp_err});
        @(posedge pclk); #1;
        if (wr && !exp_err) m_regs[d][idx] = data;
        if (exp_err && m_err[d] < 255) m_err[d]++;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        check("pready_clr", {31'b0, o_pready}, 32'h0);
        check("err_count", {24'b0, o_err_count}, 32'(m_err[d]));
    endtask

    initial begin
        logic [31:0] a;
        cur = 0; preset = 1'b1; psel_a = 0; psel_b = 0; penable = 0;
        pwrite = 0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_prdata_a", prdata_a, 32'h0);
        check("rst_pready_a", {31'b0, pready_a}, 32'h0);
        check("rst_pslverr_a", {31'b0, pslverr_a}, 32'h0);
        check("rst_errcnt_a", {24'b0, err_count_a}, 32'h0);
        check("rst_prdata_b", prdata_b, 32'h0);
        check("rst_pready_b", {31'b0, pready_b}, 32'h0);
        check("rst_errcnt_b", {24'b0, err_count_b}, 32'h0);
        preset = 1'b0;
        model_reset();
        @(posedge pclk); #1;

        // penable without a setup phase must not start a transfer or write
        psel_a = 1; penable = 1; pwrite = 1; paddr = 32'h8; pwdata = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        check("nosetup_pready1", {31'b0, pready_a}, 32'h0);
        @(posedge pclk); #1;
        check("nosetup_pready2", {31'b0, pready_a}, 32'h0);
        psel_a = 0; penable = 0;
        @(posedge pclk); #1;
        xfer(0, 0, 32'h8, 0);

        xfer(0, 1, 32'h4, 32'hDEAD_BEEF);
        xfer(0, 0, 32'h4, 0);
        xfer(1, 0, 32'h8, 0);
        xfer(0, 0, 32'h40, 0);
        xfer(0, 1, 32'h6, 32'h5555_5555);
        xfer(0, 0, 32'h4, 0);
        xfer(0, 1, 32'h0, 32'h1234);
        xfer(0, 0, 32'h0, 0);

        // abort: psel dropped during wait states
        cur = 1; psel_b = 1; penable = 0; pwrite = 1; paddr = 32'hC; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        penable = 1;
        check("abort_wait1", {31'b0, pready_b}, 32'h0);
        @(posedge pclk); #1;
        check("abort_wait2", {31'b0, pready_b}, 32'h0);
        psel_b = 0; penable = 0;
        @(posedge pclk); #1;
        check("abort_pready", {31'b0, pready_b}, 32'h0);
        xfer(1, 0, 32'hC, 0);
        xfer(1, 1, 32'h10, 32'h1357_9BDF);
        xfer(1, 0, 32'h10, 0);

        for (int k = 0; k < 150; k++) begin
            a = 32'($urandom_range(0, 19)) * 32'd4;
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge pclk); #1;
            end
        end

        // asynchronous reset in the wait state of a write
        xfer(1, 0, 32'h44, 0);
        cur = 1; psel_b = 1; penable = 0; pwrite = 1; paddr = 32'h10; pwdata = 32'hFFFF_0000;
        @(posedge pclk); #1;
        penable = 1;
        @(posedge pclk); #2;
        preset = 1'b1;
        #1;
        check("midrst_prdata", prdata_b, 32'h0);
        check("midrst_pready", {31'b0, pready_b}, 32'h0);
        check("midrst_pslverr", {31'b0, pslverr_b}, 32'h0);
        check("midrst_errcnt_b", {24'b0, err_count_b}, 32'h0);
        check("midrst_errcnt_a", {24'b0, err_count_a}, 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0; psel_b = 0; penable = 0;
        model_reset();
        @(posedge pclk); #1;
        xfer(1, 0, 32'h10, 0);

        for (int k = 0; k < 260; k++) begin
            xfer(0, 0, 32'h100 + 32'($urandom_range(0, 255)), 0);
        end
        check("sat_errcnt", {24'b0, err_count_a}, 32'hFF);
        xfer(0, 0, 32'h4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
